ncl_ring_source_gen_p: RTL

Parametrised, clocked successor to the 2-rail ring source generator. Emits a stream of WIDTH-digit dual-rail DATA wavefronts, each separated by an all-NULL spacer, into an NCL pipeline. Obeys the pipeline's completion handshake and supports four token-sequencing modes with an optional token limit. Sits at the clocked/NCL boundary as the test source for the steering pipelines.

---
 rtl/ncl_gen_pkg.sv | 68 ++++++
 rtl/ncl_comp_sync.sv | 31 +++
 rtl/ncl_ring_source_gen_p.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ncl_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ncl_gen_pkg
// Description : Shared types and helpers for the clocked NCL ring source:
//               token sequencing modes, FSM states, dual-rail encoding and
//               next-token computation.
// Revision    : 1.0 - initial release
// ============================================================================
package ncl_gen_pkg;

    // Widest token the helpers handle; callers cast down to their own width.
    localparam int MAX_W = 32;

    typedef enum logic [1:0] {
        MODE_ROTATE   = 2'd0,
        MODE_COUNT    = 2'd1,
        MODE_LFSR     = 2'd2,
        MODE_RAILSWAP = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DATA_WAIT = 2'd1,
        NULL_WAIT = 2'd2,
        DONE      = 2'd3
    } state_e;

    // Digit i becomes {rail1, rail0} = {b, ~b}: always complete, one-hot.
    function automatic logic [2*MAX_W-1:0] dr_encode(input logic [MAX_W-1:0] value);
        logic [2*MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++) begin
            r[2*i+1] = value[i];
            r[2*i]   = ~value[i];
        end
        return r;
    endfunction

    // Successor token within 'width' bits. LFSR is a right-shifting Galois
    // form: shift toward bit 0, XOR the tap mask when a 1 falls out. Zero is
    // not on the LFSR cycle, so it is kicked to 1.
    function automatic logic [MAX_W-1:0] next_token(input logic [MAX_W-1:0] value,
                                                    input mode_e            seq_mode,
                                                    input logic [MAX_W-1:0] taps,
                                                    input int               width);
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] v;
        logic [MAX_W-1:0] r;
        mask = '0;
        for (int i = 0; i < MAX_W; i++) begin
            mask[i] = (i < width);
        end
        v = value & mask;
        case (seq_mode)
            MODE_ROTATE: r = (v << 1) | (v >> (width - 1));
            MODE_COUNT:  r = v + MAX_W'(1);
            MODE_LFSR: begin
                if (v == '0)   r = MAX_W'(1);
                else if (v[0]) r = (v >> 1) ^ taps;
                else           r = v >> 1;
            end
            default:     r = ~v;
        endcase
        return r & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ncl_comp_sync.sv
`default_nettype none
// ============================================================================
// Module      : ncl_comp_sync
// Description : Multi-flop synchroniser bringing the asynchronous NCL
//               completion signal into the clock domain. Clears to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module ncl_comp_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic init_n,
    input  logic i_tcomp,
    output logic o_tcomp_s
);

    logic [SYNC_STAGES-1:0] r_sync;

    // Shift the raw completion level through the synchroniser chain.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_tcomp};
        end
    end

    assign o_tcomp_s = r_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/ncl_ring_source_gen_p.sv
`default_nettype none
// ============================================================================
// Module      : ncl_ring_source_gen_p
// Description : Clocked dual-rail token source for NCL pipelines. Emits DATA
//               wavefronts separated by full NULL spacers, paced by the
//               synchronised completion handshake, with four sequencing
//               modes and an optional token limit.
// Revision    : 1.0 - initial release
// ============================================================================
module ncl_ring_source_gen_p
    import ncl_gen_pkg::*;
#(
    parameter int               WIDTH       = 4,
    parameter int               TOKENS      = 0,
    parameter logic [WIDTH-1:0] SEED        = WIDTH'(1),
    parameter logic [WIDTH-1:0] LFSR_TAPS   = WIDTH'(4'b1001),
    parameter int               NULL_HOLD   = 1,
    parameter int               SYNC_STAGES = 2,
    parameter int               CNT_W       = 16
) (
    input  logic               clk,
    input  logic               init_n,
    input  logic               run,
    input  logic [1:0]         mode,
    input  logic               tcomp,
    output logic [2*WIDTH-1:0] c,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   token_cnt
);

    localparam int                  c_HOLD_W    = (NULL_HOLD > 1) ? $clog2(NULL_HOLD) : 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(NULL_HOLD - 1);
    localparam logic [CNT_W-1:0]    c_TOK_LIMIT = CNT_W'(TOKENS);
    localparam bit                  c_LIMITED   = (TOKENS != 0);

    logic                w_tcomp_s;
    state_e              r_state;
    state_e              w_state_nxt;
    logic [WIDTH-1:0]    r_value;
    logic [WIDTH-1:0]    w_value_nxt;
    logic [WIDTH-1:0]    w_value_succ;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [c_HOLD_W-1:0] r_hold;
    logic [c_HOLD_W-1:0] w_hold_nxt;
    logic                w_hold_met;
    logic [2*WIDTH-1:0]  w_c_data;
    logic [2*WIDTH-1:0]  r_c;
    logic [2*WIDTH-1:0]  w_c_nxt;
    logic                r_busy;
    logic                w_busy_nxt;
    logic                r_done;
    logic                w_done_nxt;

    ncl_comp_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_comp_sync (
        .clk       (clk),
        .init_n    (init_n),
        .i_tcomp   (tcomp),
        .o_tcomp_s (w_tcomp_s)
    );

    // mode is only consumed on the DATA->NULL edge, so this value is only
    // latched there.
    assign w_value_succ = WIDTH'(next_token(MAX_W'(r_value), mode_e'(mode),
                                            MAX_W'(LFSR_TAPS), WIDTH));
    assign w_c_data     = (2*WIDTH)'(dr_encode(MAX_W'(r_value)));
    // The hold counter saturates at its last value, so equality is enough.
    assign w_hold_met   = (r_hold == c_HOLD_LAST);

    // Next-state and next-output decode for the token handshake.
    always_comb begin
        w_state_nxt = r_state;
        w_value_nxt = r_value;
        w_cnt_nxt   = r_cnt;
        w_hold_nxt  = r_hold;
        case (r_state)
            IDLE: begin
                if (run && !w_tcomp_s) w_state_nxt = DATA_WAIT;
            end
            DATA_WAIT: begin
                // run is deliberately ignored here: a started token always completes.
                if (w_tcomp_s) begin
                    w_state_nxt = NULL_WAIT;
                    w_cnt_nxt   = r_cnt + 1'b1;
                    w_value_nxt = w_value_succ;
                    w_hold_nxt  = '0;
                end
            end
            NULL_WAIT: begin
                if (!w_hold_met) w_hold_nxt = r_hold + 1'b1;
                if (w_hold_met && !w_tcomp_s) begin
                    if (c_LIMITED && (r_cnt == c_TOK_LIMIT)) w_state_nxt = DONE;
                    else if (run)                            w_state_nxt = DATA_WAIT;
                    else                                     w_state_nxt = IDLE;
                end
            end
            DONE: begin
                if (!run) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_value_nxt = SEED;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        // Outputs follow the state being entered so every output is a flop.
        w_c_nxt    = (w_state_nxt == DATA_WAIT) ? w_c_data : '0;
        w_busy_nxt = (w_state_nxt == DATA_WAIT) || (w_state_nxt == NULL_WAIT);
        w_done_nxt = (w_state_nxt == DONE);
    end

    // State, token and registered-output update with asynchronous clear.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            r_state <= IDLE;
            r_value <= SEED;
            r_cnt   <= '0;
            r_hold  <= '0;
            r_c     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_value <= w_value_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hold  <= w_hold_nxt;
            r_c     <= w_c_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign c         = r_c;
    assign busy      = r_busy;
    assign done      = r_done;
    assign token_cnt = r_cnt;

endmodule
`default_nettype wire
